// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: oversampled UART transmitter with a valid/ready byte interface.
//
// A byte is accepted when tx_valid and tx_ready are both high at a rising
// clk edge. It is then sent as a frame on tx: start bit (0), DATA_BITS data
// bits LSB first, an optional parity bit, and STOP_BITS stop bits (1).
// Each bit lasts OVERSAMPLING baud_tick pulses. clk cycles without a
// baud_tick do not advance the frame.
//
// Parameters:
//   DATA_BITS    payload bits per frame (5..9)
//   OVERSAMPLING baud_tick pulses per bit period (2..64)
//   PARITY_EN    1 inserts a parity bit after the data bits
//   PARITY_ODD   0 = even parity, 1 = odd parity
//   STOP_BITS    stop bits per frame (1..2)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   baud_tick  one-clk enable pulse at BAUD_RATE*OVERSAMPLING
//   tx_data    payload, sampled on accept
//   tx_valid   requester has a byte to send
//   tx_ready   high exactly while idle; a byte can be accepted this cycle
//   tx         registered serial line, idle high
//   busy       high while a frame is in progress (inverse of tx_ready)
//   tx_done    one-clk pulse when a frame completes
module uart_tx_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int OVERSAMPLING = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int CNT_W = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLING - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     tick_cnt, tick_cnt_n;
    logic [BIT_W-1:0]     bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shift_reg, shift_reg_n;
    logic                 par_bit, par_bit_n;
    logic                 tx_n;
    logic                 tx_done_n;
    logic                 tick_end;

    assign tx_ready = (state == IDLE);
    assign busy     = ~tx_ready;

    // Last baud_tick of the current bit period.
    assign tick_end = baud_tick && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_reg_n;
            par_bit   <= par_bit_n;
            tx        <= tx_n;
            tx_done   <= tx_done_n;
        end
    end

    always_comb begin
        state_n     = state;
        tick_cnt_n  = tick_cnt;
        bit_idx_n   = bit_idx;
        shift_reg_n = shift_reg;
        par_bit_n   = par_bit;
        tx_n        = tx;
        tx_done_n   = 1'b0;

        if (state != IDLE && baud_tick) begin
            tick_cnt_n = tick_end ? '0 : tick_cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (tx_valid) begin
                    // Parity is computed from the byte as accepted, so later
                    // shifting of shift_reg does not disturb it.
                    shift_reg_n = tx_data;
                    par_bit_n   = (^tx_data) ^ (PARITY_ODD != 0);
                    tick_cnt_n  = '0;
                    bit_idx_n   = '0;
                    tx_n        = 1'b0;
                    state_n     = START;
                end
            end

            START: begin
                if (tick_end) begin
                    bit_idx_n = '0;
                    tx_n      = shift_reg[0];
                    state_n   = DATA;
                end
            end

            DATA: begin
                if (tick_end) begin
                    if (bit_idx == DATA_LAST) begin
                        bit_idx_n = '0;
                        if (PARITY_EN != 0) begin
                            tx_n    = par_bit;
                            state_n = PARITY;
                        end else begin
                            tx_n    = 1'b1;
                            state_n = STOP;
                        end
                    end else begin
                        // tx is loaded with the bit that becomes shift_reg[0]
                        // after this shift, keeping the line registered.
                        bit_idx_n   = bit_idx + BIT_W'(1);
                        shift_reg_n = shift_reg >> 1;
                        tx_n        = shift_reg[1];
                    end
                end
            end

            PARITY: begin
                if (tick_end) begin
                    bit_idx_n = '0;
                    tx_n      = 1'b1;
                    state_n   = STOP;
                end
            end

            STOP: begin
                if (tick_end) begin
                    if (bit_idx == STOP_LAST) begin
                        bit_idx_n = '0;
                        tx_n      = 1'b1;
                        tx_done_n = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        bit_idx_n = bit_idx + BIT_W'(1);
                    end
                end
            end

            default: begin
                tx_n    = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed bench for uart_tx_ctrl.
// Four instances share clk, rst, baud_tick and tx_data:
//   0 defaults, 1 even parity, 2 odd parity, 3 two stop bits.
// baud_tick pulses every 4 clk. Expected frames are hand-written bit
// strings, first character = first bit on the line.
module tb_uart_tx_ctrl;

    localparam int OS = 16;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic       tv     [4];
    logic       tx_w   [4];
    logic       rdy_w  [4];
    logic       busy_w [4];
    logic       done_w [4];

    int total = 0;
    int bad   = 0;
    int bdiv  = 0;

    uart_tx_ctrl u0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tv[0]), .tx_ready(rdy_w[0]), .tx(tx_w[0]),
        .busy(busy_w[0]), .tx_done(done_w[0])
    );

    uart_tx_ctrl #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tv[1]), .tx_ready(rdy_w[1]), .tx(tx_w[1]),
        .busy(busy_w[1]), .tx_done(done_w[1])
    );

    uart_tx_ctrl #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tv[2]), .tx_ready(rdy_w[2]), .tx(tx_w[2]),
        .busy(busy_w[2]), .tx_done(done_w[2])
    );

    uart_tx_ctrl #(.STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tv[3]), .tx_ready(rdy_w[3]), .tx(tx_w[3]),
        .busy(busy_w[3]), .tx_done(done_w[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // baud_tick: one clk high out of every four, changed on the falling edge.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            bdiv      = (bdiv + 1) % 4;
            baud_tick = (bdiv == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int         sel;
        logic [7:0] data;
        string      exp;
        bit         align;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // mode 0: one-clk valid; 1: hold valid, change tx_data to AA after accept;
    // 2: one-clk valid, change tx_data to FF after accept.
    task automatic run_frame(input int sel, input logic [7:0] data, input string exp,
                             input bit align, input int mode);
        int ticks;
        int done_tick;
        int bi;
        int budget;
        logic bt;
        ticks     = 0;
        done_tick = -1;
        for (int w = 0; w < 16; w++) begin
            @(negedge clk);
            #1;
            if (!align || baud_tick) break;
        end
        tv[sel] = 1'b1;
        tx_data = data;
        @(posedge clk);
        #1;
        check($sformatf("accept_ready_u%0d", sel), rdy_w[sel], 0);
        check($sformatf("accept_busy_u%0d", sel), busy_w[sel], 1);
        check($sformatf("start_edge_u%0d", sel), tx_w[sel], 0);
        if (mode == 1) begin
            tx_data = 8'hAA;
        end else begin
            tv[sel] = 1'b0;
            if (mode == 2) tx_data = 8'hFF;
        end
        budget = exp.len() * OS * 4 + 64;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            bt = baud_tick;
            if (bt) ticks++;
            #1;
            if (bt && (ticks % OS) == OS / 2) begin
                bi = ticks / OS;
                if (bi < exp.len())
                    check($sformatf("u%0d_%0h_bit%0d", sel, data, bi), tx_w[sel],
                          (exp[bi] == "1") ? 1 : 0);
            end
            if (done_w[sel]) begin
                done_tick = ticks;
                break;
            end
        end
        check($sformatf("u%0d_%0h_frame_ticks", sel, data), done_tick, exp.len() * OS);
        check($sformatf("u%0d_done_ready", sel), rdy_w[sel], 1);
        check($sformatf("u%0d_done_line", sel), tx_w[sel], 1);
        if (mode != 1) begin
            @(posedge clk);
            #1;
            check($sformatf("u%0d_done_pulse", sel), done_w[sel], 0);
            check($sformatf("u%0d_idle_line", sel), tx_w[sel], 1);
        end
    endtask

    initial begin
        int   ticks;
        logic seen_done;

        vecs[0] = '{0, 8'hA5, "0101001011",  1'b0};
        vecs[1] = '{1, 8'h07, "01110000011", 1'b0};
        vecs[2] = '{2, 8'h07, "01110000001", 1'b0};
        vecs[3] = '{1, 8'h03, "01100000001", 1'b0};
        vecs[4] = '{3, 8'h81, "01000000111", 1'b1};
        vecs[5] = '{0, 8'h3C, "0001111001",  1'b1};

        rst     = 1'b1;
        tx_data = 8'h00;
        for (int s = 0; s < 4; s++) tv[s] = 1'b0;

        #2;
        for (int s = 0; s < 4; s++) begin
            check($sformatf("rst_tx_u%0d", s), tx_w[s], 1);
            check($sformatf("rst_ready_u%0d", s), rdy_w[s], 1);
            check($sformatf("rst_busy_u%0d", s), busy_w[s], 0);
            check($sformatf("rst_done_u%0d", s), done_w[s], 0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle with baud_tick running: line stays high, nothing starts.
        repeat (20) @(posedge clk);
        #1;
        check("idle_tx", tx_w[0], 1);
        check("idle_ready", rdy_w[0], 1);

        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].sel, vecs[i].data, vecs[i].exp, vecs[i].align, 0);

        // Back-to-back frames with tx_valid held high.
        run_frame(0, 8'h55, "0101010101", 1'b0, 1);
        run_frame(0, 8'hAA, "0010101011", 1'b0, 0);

        // tx_data changed right after accept must not reach the line.
        run_frame(0, 8'h12, "0010010001", 1'b0, 2);

        // Reset at tick 50 of a frame.
        @(negedge clk);
        #1;
        tv[0]   = 1'b1;
        tx_data = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        tv[0]     = 1'b0;
        ticks     = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            if (baud_tick) ticks++;
            #1;
            if (done_w[0]) seen_done = 1'b1;
            if (ticks == 50) break;
        end
        check("abort_reached_tick", ticks, 50);
        check("abort_no_early_done", seen_done, 0);
        check("abort_busy_before", busy_w[0], 1);
        rst = 1'b1;
        #1;
        check("abort_tx", tx_w[0], 1);
        check("abort_ready", rdy_w[0], 1);
        check("abort_busy", busy_w[0], 0);
        check("abort_done", done_w[0], 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("abort_done_hold", done_w[0], 0);
        end
        rst = 1'b0;
        run_frame(0, 8'h3C, "0001111001", 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
